// File: rtl/encoders_events_pkg.sv
// Shared types and field layout for the encoders event queue.
// Each encoder occupies one 16-bit half of R0/R1/R2:
//   [3:0] normal position, [7:4] pressed position, [14:8] duration (ignored),
//   [15] button. Encoder k lives in register k/2, half k%2; encoder 4 is R2[15:0].
// Control 5 is the standalone button on R2[31].
package encoders_events_pkg;

  localparam int N_CONTROLS   = 6;
  localparam int NPOS_LSB     = 0;
  localparam int PPOS_LSB     = 4;
  localparam int BTN_BIT      = 15;
  localparam int SOLO_BTN_BIT = 31;

  typedef enum logic [1:0] {
    ROT_N   = 2'd0,
    ROT_P   = 2'd1,
    PRESS   = 2'd2,
    RELEASE = 2'd3
  } evt_type_e;

  typedef struct packed {
    logic [2:0] idx;
    evt_type_e  etype;
    logic [2:0] rsvd;
    logic [3:0] pos;
    logic [3:0] delta;
  } evt_t;

  typedef struct packed {
    logic [3:0] npos;
    logic [3:0] ppos;
    logic       btn;
  } ctrl_state_t;

  // Pull the fields of control k out of the packed board registers.
  function automatic ctrl_state_t extract_ctrl(input logic [31:0] r0,
                                               input logic [31:0] r1,
                                               input logic [31:0] r2,
                                               input int          k);
    ctrl_state_t st;
    logic [15:0] half;
    half = 16'h0000;
    case (k)
      0:       half = r0[15:0];
      1:       half = r0[31:16];
      2:       half = r1[15:0];
      3:       half = r1[31:16];
      default: half = r2[15:0];
    endcase
    if (k == N_CONTROLS - 1) begin
      st.npos = 4'h0;
      st.ppos = 4'h0;
      st.btn  = r2[SOLO_BTN_BIT];
    end else begin
      st.npos = half[NPOS_LSB +: 4];
      st.ppos = half[PPOS_LSB +: 4];
      st.btn  = half[BTN_BIT];
    end
    return st;
  endfunction

endpackage

// File: rtl/encoder_event_fifo.sv
// Generic show-ahead FIFO.
// Ports:
//   i_clk, i_srst            clock, synchronous active-high reset
//   i_push, i_push_data      write request (dropped when full)
//   i_pop                    read request (ignored when empty)
//   o_rd_data                head entry, 0 while empty
//   o_empty, o_full, o_count occupancy status
//   o_empty_next             empty flag as it will be after this edge
module encoder_event_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_count,
  output logic             o_empty_next
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_next;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + (AW+1)'(1);
      2'b01:   w_count_next = r_count - (AW+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  assign o_empty_next = (w_count_next == '0);
  assign o_count      = r_count;
  assign o_rd_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage is not reset; the count guards every read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers are AW bits wide so they wrap mod DEPTH on their own.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

endmodule

// File: rtl/encoders_event_queue.sv
// Turns changes in the encoders board state registers into 16-bit event
// records queued for the CPU, with an interrupt while events are pending.
// Ports:
//   CLK, RESET   clock, synchronous active-high reset
//   R0, R1, R2   packed board state (encoders 0..4, standalone button R2[31])
//   IRQ_EN       interrupt enable
//   EVT_RD       pop strobe, one event per asserted cycle
//   EVT_DATA     head event (show-ahead), 0 when empty
//   EVT_EMPTY    queue empty
//   EVT_COUNT    number of queued events
//   IRQ          registered IRQ_EN & ~empty
module encoders_event_queue
  import encoders_events_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       R0,
  input  logic [31:0]       R1,
  input  logic [31:0]       R2,
  input  logic              IRQ_EN,
  input  logic              EVT_RD,
  output logic [15:0]       EVT_DATA,
  output logic              EVT_EMPTY,
  output logic [ADDR_W:0]   EVT_COUNT,
  output logic              IRQ
);

  ctrl_state_t [N_CONTROLS-1:0] w_live;
  ctrl_state_t [N_CONTROLS-1:0] r_last;
  logic [2:0]                   r_scan_idx;
  logic                         r_primed;
  logic                         r_irq;

  ctrl_state_t w_cur;
  ctrl_state_t w_ref;
  evt_t        w_evt;
  logic        w_emit;
  logic        w_upd_btn;
  logic        w_upd_npos;
  logic        w_upd_ppos;
  logic        w_push;
  logic        w_full;
  logic        w_empty_next;

  // Duration fields and R2[30:16] carry no event information.
  logic w_unused_bits;
  assign w_unused_bits = ^{R0[30:24], R0[14:8], R1[30:24], R1[14:8],
                           R2[30:16], R2[14:8]};

  for (genvar gi = 0; gi < N_CONTROLS; gi++) begin : g_live
    assign w_live[gi] = extract_ctrl(R0, R1, R2, gi);
  end

  // Select the live and last-reported state of the control being visited.
  always_comb begin
    w_cur = '0;
    w_ref = '0;
    for (int i = 0; i < N_CONTROLS; i++) begin
      if (r_scan_idx == 3'(i)) begin
        w_cur = w_live[i];
        w_ref = r_last[i];
      end
    end
  end

  // At most one event per visit: button, then normal pos, then pressed pos.
  always_comb begin
    w_emit     = 1'b0;
    w_upd_btn  = 1'b0;
    w_upd_npos = 1'b0;
    w_upd_ppos = 1'b0;
    w_evt      = '0;
    w_evt.idx  = r_scan_idx;
    if (w_cur.btn != w_ref.btn) begin
      w_emit      = 1'b1;
      w_upd_btn   = 1'b1;
      w_evt.etype = w_cur.btn ? PRESS : RELEASE;
    end else if (w_cur.npos != w_ref.npos) begin
      w_emit      = 1'b1;
      w_upd_npos  = 1'b1;
      w_evt.etype = ROT_N;
      w_evt.pos   = w_cur.npos;
      w_evt.delta = w_cur.npos - w_ref.npos;
    end else if (w_cur.ppos != w_ref.ppos) begin
      w_emit      = 1'b1;
      w_upd_ppos  = 1'b1;
      w_evt.etype = ROT_P;
      w_evt.pos   = w_cur.ppos;
      w_evt.delta = w_cur.ppos - w_ref.ppos;
    end
  end

  // A blocked push leaves last-reported untouched, so the change stays pending.
  assign w_push = r_primed & w_emit & ~w_full;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_primed   <= 1'b0;
      r_scan_idx <= 3'd0;
      r_last     <= '0;
    end else if (!r_primed) begin
      r_primed <= 1'b1;
      r_last   <= w_live;
    end else begin
      r_scan_idx <= (r_scan_idx == 3'(N_CONTROLS - 1)) ? 3'd0 : r_scan_idx + 3'd1;
      for (int i = 0; i < N_CONTROLS; i++) begin
        if (w_push && (r_scan_idx == 3'(i))) begin
          if (w_upd_btn)  r_last[i].btn  <= w_cur.btn;
          if (w_upd_npos) r_last[i].npos <= w_cur.npos;
          if (w_upd_ppos) r_last[i].ppos <= w_cur.ppos;
        end
      end
    end
  end

  encoder_event_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk        (CLK),
    .i_srst       (RESET),
    .i_push       (w_push),
    .i_push_data  (w_evt),
    .i_pop        (EVT_RD),
    .o_rd_data    (EVT_DATA),
    .o_empty      (EVT_EMPTY),
    .o_full       (w_full),
    .o_count      (EVT_COUNT),
    .o_empty_next (w_empty_next)
  );

  // Registered from the next-state empty flag so IRQ tracks EVT_EMPTY exactly.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= IRQ_EN & ~w_empty_next;
    end
  end

  assign IRQ = r_irq;

endmodule

// File: tb/tb_encoders_event_queue.sv
module tb_encoders_event_queue;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   r0, r1, r2;
  logic          irq_en;
  logic          evt_rd;
  logic [15:0]   evt_data;
  logic          evt_empty;
  logic [AW:0]   evt_count;
  logic          irq;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: last-reported fields per control plus expected events.
  logic [3:0]  m_npos [6];
  logic [3:0]  m_ppos [6];
  logic        m_btn  [6];
  logic [15:0] exp_q  [$];

  always #5 clk = ~clk;

  encoders_event_queue #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .R0        (r0),
    .R1        (r1),
    .R2        (r2),
    .IRQ_EN    (irq_en),
    .EVT_RD    (evt_rd),
    .EVT_DATA  (evt_data),
    .EVT_EMPTY (evt_empty),
    .EVT_COUNT (evt_count),
    .IRQ       (irq)
  );

  function automatic logic [15:0] mk_evt(input int idx, input int typ,
                                         input logic [3:0] pos, input logic [3:0] delta);
    return {3'(idx), 2'(typ), 3'b000, pos, delta};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop(output logic [15:0] d);
    d = evt_data;
    evt_rd = 1'b1;
    @(negedge clk);
    evt_rd = 1'b0;
  endtask

  task automatic get_fields(input int k, output logic [3:0] np,
                            output logic [3:0] pp, output logic b);
    logic [15:0] s;
    if (k == 5) begin
      np = 4'h0; pp = 4'h0; b = r2[31];
    end else begin
      s = (k == 0) ? r0[15:0] : (k == 1) ? r0[31:16] :
          (k == 2) ? r1[15:0] : (k == 3) ? r1[31:16] : r2[15:0];
      np = s[3:0]; pp = s[7:4]; b = s[15];
    end
  endtask

  task automatic model_sync();
    for (int k = 0; k < 6; k++) get_fields(k, m_npos[k], m_ppos[k], m_btn[k]);
    exp_q.delete();
  endtask

  // Expected events for a change of control k, in reporting priority order.
  task automatic model_diff(input int k);
    logic [3:0] np, pp, d;
    logic b;
    get_fields(k, np, pp, b);
    if (b != m_btn[k]) exp_q.push_back(mk_evt(k, b ? 2 : 3, 4'h0, 4'h0));
    if (np != m_npos[k]) begin
      d = np - m_npos[k];
      exp_q.push_back(mk_evt(k, 0, np, d));
    end
    if (pp != m_ppos[k]) begin
      d = pp - m_ppos[k];
      exp_q.push_back(mk_evt(k, 1, pp, d));
    end
    m_npos[k] = np; m_ppos[k] = pp; m_btn[k] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; r0 = 32'h0000_8053; r1 = 32'h0; r2 = 32'h0;
    irq_en = 1'b0; evt_rd = 1'b0;
    tick(3);
    n_checks++; if (evt_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b expected 1", evt_empty); end
    n_checks++; if (evt_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", evt_count); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if (evt_data !== 16'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 0000", evt_data); end
    rst = 1'b0;
    tick(20);
    n_checks++; if (evt_empty !== 1'b1) begin n_errors++; $display("FAIL prime_empty: got %b expected 1", evt_empty); end
    n_checks++; if (evt_count !== '0) begin n_errors++; $display("FAIL prime_count: got %0d expected 0", evt_count); end
    $display("test_reset done");
  endtask

  task automatic test_rotation();
    logic ok;
    logic [15:0] d;
    irq_en = 1'b1;
    r0 = 32'h0000_8055;
    ok = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (!evt_empty) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL rot_latency: got empty after 7 cycles expected event"); end
    n_checks++; if (evt_data !== 16'h0052) begin n_errors++; $display("FAIL rot_data: got %h expected 0052", evt_data); end
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL rot_irq: got %b expected 1", irq); end
    pop(d);
    n_checks++; if (evt_empty !== 1'b1) begin n_errors++; $display("FAIL rot_pop_empty: got %b expected 1", evt_empty); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL rot_pop_irq: got %b expected 0", irq); end
    $display("test_rotation done data=%h", d);
  endtask

  task automatic test_wrap_priority();
    logic [15:0] d;
    r1 = 32'h0000_0001;
    tick(8);
    n_checks++; if (evt_data !== 16'h4011) begin n_errors++; $display("FAIL wrap_setup: got %h expected 4011", evt_data); end
    pop(d);
    r1 = 32'h0000_800F;
    tick(14);
    n_checks++; if (evt_count !== 2) begin n_errors++; $display("FAIL wrap_count: got %0d expected 2", evt_count); end
    pop(d);
    n_checks++; if (d !== 16'h5000) begin n_errors++; $display("FAIL wrap_press: got %h expected 5000", d); end
    pop(d);
    n_checks++; if (d !== 16'h40FE) begin n_errors++; $display("FAIL wrap_rot: got %h expected 40fe", d); end
    $display("test_wrap_priority done");
  endtask

  task automatic test_solo_button();
    logic [15:0] d;
    r2[31] = 1'b1;
    tick(10);
    r2[31] = 1'b0;
    tick(10);
    n_checks++; if (evt_count !== 2) begin n_errors++; $display("FAIL solo_count: got %0d expected 2", evt_count); end
    pop(d);
    n_checks++; if (d !== 16'hB000) begin n_errors++; $display("FAIL solo_press: got %h expected b000", d); end
    pop(d);
    n_checks++; if (d !== 16'hB800) begin n_errors++; $display("FAIL solo_release: got %h expected b800", d); end
    $display("test_solo_button done");
  endtask

  task automatic test_full();
    logic [15:0] d;
    logic [3:0]  seen;
    logic        ok;
    r0 = 32'h0001_8056;
    r1 = 32'h0001_800E;
    tick(10);
    n_checks++; if (evt_count !== 4) begin n_errors++; $display("FAIL full_count: got %0d expected 4", evt_count); end
    r2 = 32'h0000_0001; tick(10);
    r2 = 32'h0000_0002; tick(3);
    r2 = 32'h0000_0003; tick(3);
    r2 = 32'h0000_0004; tick(10);
    n_checks++; if (evt_count !== 4) begin n_errors++; $display("FAIL full_hold: got %0d expected 4", evt_count); end
    seen = 4'h0;
    for (int n = 0; n < 4; n++) begin
      pop(d);
      case (d)
        16'h0061: seen[0] = 1'b1;
        16'h2011: seen[1] = 1'b1;
        16'h40EF: seen[2] = 1'b1;
        16'h6011: seen[3] = 1'b1;
        default:  seen = seen;
      endcase
      if (n == 0) begin
        ok = 1'b0;
        for (int i = 0; i < 7; i++) begin
          if (evt_count == 4) begin ok = 1'b1; break; end
          tick(1);
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL full_refill: got count %0d expected 4", evt_count); end
      end
    end
    n_checks++; if (seen !== 4'hF) begin n_errors++; $display("FAIL full_set: got mask %b expected 1111", seen); end
    pop(d);
    n_checks++; if (d !== 16'h8044) begin n_errors++; $display("FAIL full_coalesce: got %h expected 8044", d); end
    n_checks++; if (evt_count !== 0) begin n_errors++; $display("FAIL full_drain: got %0d expected 0", evt_count); end
    $display("test_full done");
  endtask

  task automatic test_edge_cases();
    logic [15:0] d;
    logic        ok;
    evt_rd = 1'b1; tick(1); evt_rd = 1'b0;
    n_checks++; if (evt_count !== 0) begin n_errors++; $display("FAIL empty_rd_count: got %0d expected 0", evt_count); end
    n_checks++; if (evt_empty !== 1'b1) begin n_errors++; $display("FAIL empty_rd_empty: got %b expected 1", evt_empty); end

    // Use the observed push of control 0 to align with the scanner phase.
    r0 = 32'h0001_8057;
    ok = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (evt_count == 1) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL pp_setup: got count %0d expected 1", evt_count); end
    r1 = 32'h0001_800D;
    tick(2);
    n_checks++; if (evt_count !== 2) begin n_errors++; $display("FAIL pp_count2: got %0d expected 2", evt_count); end
    r2 = 32'h0000_0005;
    tick(1);
    d = evt_data;
    evt_rd = 1'b1; tick(1); evt_rd = 1'b0;
    n_checks++; if (evt_count !== 2) begin n_errors++; $display("FAIL push_pop_count: got %0d expected 2", evt_count); end
    n_checks++; if (d !== 16'h0071) begin n_errors++; $display("FAIL push_pop_head: got %h expected 0071", d); end
    pop(d);
    n_checks++; if (d !== 16'h40DF) begin n_errors++; $display("FAIL push_pop_2nd: got %h expected 40df", d); end
    pop(d);
    n_checks++; if (d !== 16'h8051) begin n_errors++; $display("FAIL push_pop_3rd: got %h expected 8051", d); end

    // Reset while events are queued; registers also change under reset.
    r0 = 32'h0001_8058;
    r1 = 32'h0002_800D;
    tick(8);
    rst = 1'b1;
    r0 = 32'h0003_8059;
    tick(1);
    n_checks++; if (evt_count !== 0) begin n_errors++; $display("FAIL midrst_count: got %0d expected 0", evt_count); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL midrst_irq: got %b expected 0", irq); end
    tick(1);
    rst = 1'b0;
    tick(20);
    n_checks++; if (evt_count !== 0) begin n_errors++; $display("FAIL reprime_count: got %0d expected 0", evt_count); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reprime_irq: got %b expected 0", irq); end
    $display("test_edge_cases done");
  endtask

  task automatic test_random();
    logic [15:0] s, d, e;
    int k, nexp;
    model_sync();
    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(0, 5);
      if (k == 5) begin
        r2[31] = ~r2[31];
        r2[30:16] = 15'($urandom);
      end else begin
        s = (k == 0) ? r0[15:0] : (k == 1) ? r0[31:16] :
            (k == 2) ? r1[15:0] : (k == 3) ? r1[31:16] : r2[15:0];
        if ($urandom_range(0, 1) == 1) s[3:0] = 4'($urandom);
        if ($urandom_range(0, 1) == 1) s[7:4] = 4'($urandom);
        if ($urandom_range(0, 1) == 1) s[15] = ~s[15];
        s[14:8] = 7'($urandom);
        case (k)
          0:       r0[15:0]  = s;
          1:       r0[31:16] = s;
          2:       r1[15:0]  = s;
          3:       r1[31:16] = s;
          default: r2[15:0]  = s;
        endcase
      end
      model_diff(k);
      nexp = exp_q.size();
      tick(20);
      n_checks++; if (evt_count !== (AW+1)'(nexp)) begin n_errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", it, evt_count, nexp); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pop(d);
        n_checks++; if (d !== e) begin n_errors++; $display("FAIL rand_evt[%0d]: got %h expected %h", it, d, e); end
      end
      $display("rand step %0d ctrl=%0d events=%0d", it, k, nexp);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap_priority();
    test_solo_button();
    test_full();
    test_edge_cases();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
